// File: rtl/ram_dma_if.sv
// Single-port synchronous RAM bus: address, write data, write enable and
// read data that is registered inside the RAM (one-cycle latency).
interface ram_dma_if #(
  parameter int AW = 14
);
  logic [AW-1:0] a;
  logic [7:0]    d;
  logic          w;
  logic [7:0]    q;

  modport master (output a, d, w, input q);
  modport slave  (input a, d, w, output q);
endinterface

// File: rtl/ram_dma.sv
// Block-transfer engine for the RAM bus: forward byte copy (LDIR-style)
// at 2 cycles/byte and constant fill at 1 cycle/byte.
module ram_dma #(
  parameter int AW = 14,
  parameter int LW = 14
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [7:0]    value,
  output logic          busy,
  output logic          done,
  ram_dma_if.master     ram
);

  typedef enum logic [1:0] {IDLE, RD, WR, FILL} state_t;

  state_t        state;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic [LW-1:0] cnt;
  logic [7:0]    fill_val;

  // Transfer sequencer; request fields are latched on the accepted start so
  // later input changes cannot disturb a running transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      cnt      <= '0;
      fill_val <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr  <= src;
            dst_ptr  <= dst;
            cnt      <= len;
            fill_val <= value;
            if (len == '0) begin
              done <= 1'b1;
            end else if (mode) begin
              state <= FILL;
              busy  <= 1'b1;
            end else begin
              state <= RD;
              busy  <= 1'b1;
            end
          end
        end
        RD: state <= WR;
        WR: begin
          // Pointers wrap silently at 2^AW.
          src_ptr <= src_ptr + 1'b1;
          dst_ptr <= dst_ptr + 1'b1;
          cnt     <= cnt - 1'b1;
          if (cnt == LW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RD;
          end
        end
        FILL: begin
          dst_ptr <= dst_ptr + 1'b1;
          cnt     <= cnt - 1'b1;
          if (cnt == LW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM drive decoded from state; WR forwards q, which holds the byte
  // addressed during the preceding RD cycle.
  always_comb begin
    ram.a = '0;
    ram.d = '0;
    ram.w = 1'b0;
    case (state)
      RD: ram.a = src_ptr;
      WR: begin
        ram.a = dst_ptr;
        ram.d = ram.q;
        ram.w = 1'b1;
      end
      FILL: begin
        ram.a = dst_ptr;
        ram.d = fill_val;
        ram.w = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma: behavioural RAM on the bus, hand-computed
// cycle numbers and memory contents.
module tb_ram_dma;
  localparam int AW = 14;
  localparam int LW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mode  = 1'b0;
  logic [AW-1:0] src   = '0;
  logic [AW-1:0] dst   = '0;
  logic [LW-1:0] len   = '0;
  logic [7:0]    value = '0;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:(1<<AW)-1];

  ram_dma_if #(.AW(AW)) bus ();

  ram_dma #(.AW(AW), .LW(LW)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .value(value),
    .busy(busy), .done(done), .ram(bus)
  );

  always #5 clock = ~clock;

  // RAM model: write on edge, read data registered one cycle
  always @(posedge clock) begin
    if (bus.w) mem[bus.a] <= bus.d;
    bus.q <= mem[bus.a];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Launch one transfer and watch it; poke>0 re-asserts start with other
  // parameters in that cycle (must be ignored while busy).
  task automatic run(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] dd,
                     input logic [LW-1:0] l, input logic [7:0] v, input int poke,
                     output int dcyc, output int bcnt, output logic [31:0] wm, output int wc);
    @(negedge clock);
    mode = m; src = s; dst = dd; len = l; value = v; start = 1'b1;
    @(posedge clock);
    dcyc = -1; bcnt = 0; wm = '0; wc = 0;
    for (int k = 1; k < 200 && dcyc < 0; k++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (bus.w) begin
        wc++;
        if (k < 32) wm[k] = 1'b1;
      end
      if (done) dcyc = k;
      start = (k == poke);
      if (k == poke) begin
        mode = 1'b0; dst = 14'h0300; len = 14'd5; value = 8'h99;
      end
    end
    if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int dc, bc, wc;
  logic [31:0] wm;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hEE;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w", bus.w, 0);
    chk("rst_a", bus.a, 0);
    chk("rst_d", bus.d, 0);
    reset = 1'b1;

    // fill 4 bytes
    run(1'b1, 14'h0, 14'h0100, 14'd4, 8'hA5, 0, dc, bc, wm, wc);
    chk("fill_done_cyc", dc, 5);
    chk("fill_busy_cnt", bc, 4);
    chk("fill_wmask", wm, 32'h1E);
    chk("fill_m100", mem[14'h100], 8'hA5);
    chk("fill_m103", mem[14'h103], 8'hA5);
    chk("fill_m0ff", mem[14'h0FF], 8'hEE);
    chk("fill_m104", mem[14'h104], 8'hEE);

    // copy 3 bytes
    @(negedge clock);
    mem[14'h10] = 8'h11; mem[14'h11] = 8'h22; mem[14'h12] = 8'h33;
    run(1'b0, 14'h0010, 14'h0020, 14'd3, 8'h00, 0, dc, bc, wm, wc);
    chk("copy_done_cyc", dc, 7);
    chk("copy_wmask", wm, 32'h54);
    chk("copy_busy_cnt", bc, 6);
    chk("copy_m20", mem[14'h20], 8'h11);
    chk("copy_m21", mem[14'h21], 8'h22);
    chk("copy_m22", mem[14'h22], 8'h33);
    chk("copy_m23", mem[14'h23], 8'hEE);

    // overlapping copy replicates the first byte
    @(negedge clock);
    mem[14'h40] = 8'h5C;
    run(1'b0, 14'h0040, 14'h0041, 14'd3, 8'h00, 0, dc, bc, wm, wc);
    chk("ovl_m41", mem[14'h41], 8'h5C);
    chk("ovl_m42", mem[14'h42], 8'h5C);
    chk("ovl_m43", mem[14'h43], 8'h5C);
    chk("ovl_m44", mem[14'h44], 8'hEE);

    // fill across the top of memory
    run(1'b1, 14'h0, 14'h3FFE, 14'd4, 8'h77, 0, dc, bc, wm, wc);
    chk("wrap_wcount", wc, 4);
    chk("wrap_m3ffe", mem[14'h3FFE], 8'h77);
    chk("wrap_m3fff", mem[14'h3FFF], 8'h77);
    chk("wrap_m0000", mem[14'h0000], 8'h77);
    chk("wrap_m0001", mem[14'h0001], 8'h77);
    chk("wrap_m3ffd", mem[14'h3FFD], 8'hEE);
    chk("wrap_m0002", mem[14'h0002], 8'hEE);

    // len=0
    run(1'b1, 14'h0, 14'h0900, 14'd0, 8'h12, 0, dc, bc, wm, wc);
    chk("len0_done_cyc", dc, 1);
    chk("len0_busy_cnt", bc, 0);
    chk("len0_wcount", wc, 0);
    chk("len0_m900", mem[14'h900], 8'hEE);

    // start while busy is ignored
    run(1'b1, 14'h0, 14'h0200, 14'd3, 8'h5A, 2, dc, bc, wm, wc);
    chk("ign_done_cyc", dc, 4);
    chk("ign_m200", mem[14'h200], 8'h5A);
    chk("ign_m202", mem[14'h202], 8'h5A);
    chk("ign_m203", mem[14'h203], 8'hEE);
    chk("ign_m300", mem[14'h300], 8'hEE);
    @(negedge clock);
    chk("ign_idle", busy, 0);

    // start in the done cycle
    run(1'b1, 14'h0, 14'h0500, 14'd2, 8'h33, 0, dc, bc, wm, wc);
    chk("chain_done_cyc", dc, 3);
    mode = 1'b1; dst = 14'h0510; len = 14'd1; value = 8'h44; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("chain_busy", busy, 1);
    chk("chain_w", bus.w, 1);
    chk("chain_a", bus.a, 32'h510);
    chk("chain_d", bus.d, 8'h44);
    @(negedge clock);
    chk("chain_done", done, 1);
    chk("chain_m510", mem[14'h510], 8'h44);
    chk("chain_m501", mem[14'h501], 8'h33);

    // reset in cycle 5 of an 8-byte copy
    for (int i = 0; i < 8; i++) mem[14'h600 + i] = 8'(8'h60 + i);
    @(negedge clock);
    mode = 1'b0; src = 14'h0600; dst = 14'h0700; len = 14'd8; start = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("rstm_w", bus.w, 0);
    chk("rstm_a", bus.a, 0);
    chk("rstm_busy", busy, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rstm_busy_after", busy, 0);
    chk("rstm_done_after", done, 0);
    chk("rstm_m700", mem[14'h700], 8'h60);
    chk("rstm_m701", mem[14'h701], 8'h61);
    chk("rstm_m702", mem[14'h702], 8'hEE);
    run(1'b1, 14'h0, 14'h0800, 14'd2, 8'hC3, 0, dc, bc, wm, wc);
    chk("rstm_new_done", dc, 3);
    chk("rstm_new_m801", mem[14'h801], 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
